// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 32-bit datapath; drives one-hot gnt and the 4:1 mux select.
// Optional hold-timeout preemption is enabled by defining ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state, state_nx;
  logic [3:0] gnt_nx;
  logic [1:0] sel_nx;
  logic [1:0] last, last_nx;
  logic       busy_nx;
  logic [1:0] pick;
  logic       pick_vld;

  if (MAX_HOLD < 1 || MAX_HOLD > (64'd1 << HOLD_W)) begin : g_bad_max_hold
    $error("mux4_rr_arbiter: MAX_HOLD outside 1..2**HOLD_W");
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
  logic              preempt_q, preempt_nx;

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  // Search starts one past the last owner; offset 4 wraps back onto last itself.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!pick_vld && req[last + 2'(k)]) begin
        pick     = last + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    sel_nx   = sel;
    last_nx  = last;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_nx = hold_cnt;
    preempt_nx  = 1'b0;
`endif
    case (state)
      IDLE: begin
        gnt_nx = '0;
        if (pick_vld) begin
          gnt_nx   = 4'b0001 << pick;
          sel_nx   = pick;
          last_nx  = pick;
          state_nx = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_nx = '0;
`endif
        end
      end
      GRANT: begin
        // A normal release takes precedence over a timeout on the same edge.
        if (!req[sel]) begin
          gnt_nx   = '0;
          state_nx = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          gnt_nx     = '0;
          preempt_nx = 1'b1;
          state_nx   = IDLE;
        end else if (hold_cnt != '1) begin
          hold_cnt_nx = hold_cnt + HOLD_W'(1);
        end
`endif
      end
      default: begin
        gnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
    busy_nx = |gnt_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      busy  <= 1'b0;
      last  <= 2'd3;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      preempt_q <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      sel   <= sel_nx;
      busy  <= busy_nx;
      last  <= last_nx;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= hold_cnt_nx;
      preempt_q <= preempt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a cycle model pushes expected outputs, sampled DUT outputs pop and compare.
// Timeout scenarios run only when ARB_TIMEOUT_EN is defined.
module tb_mux4_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       preempt;

  mux4_rr_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(5)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .sel(sel), .busy(busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  bit       m_grant;
  bit [3:0] m_gnt;
  bit [1:0] m_sel;
  bit [1:0] m_last;
  int       m_hold;
  bit       m_pre;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit [3:0] rq);
    int idx;
    bit found;
    m_pre = 1'b0;
    if (r) begin
      m_grant = 1'b0; m_gnt = '0; m_sel = '0; m_last = 2'd3; m_hold = 0;
    end else if (!m_grant) begin
      m_gnt = '0;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        idx = (int'(m_last) + k) % 4;
        if (!found && rq[idx]) begin
          found   = 1'b1;
          m_gnt   = 4'b0001 << idx;
          m_sel   = 2'(idx);
          m_last  = 2'(idx);
          m_hold  = 0;
          m_grant = 1'b1;
        end
      end
    end else if (!rq[m_sel]) begin
      m_gnt = '0; m_grant = 1'b0;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_hold == MAXH - 1) begin
        m_gnt = '0; m_grant = 1'b0; m_pre = 1'b1;
      end else
`endif
      if (m_hold < 31) m_hold++;
    end
  endtask

  task automatic step(input bit r, input bit [3:0] rq);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    model_step(r, rq);
    sbq.push_back('{gnt: m_gnt, sel: m_sel, busy: |m_gnt, preempt: m_pre});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check("gnt", 32'(gnt), 32'(e.gnt));
      check("sel", 32'(sel), 32'(e.sel));
      check("busy", 32'(busy), 32'(e.busy));
      check("preempt", 32'(preempt), 32'(e.preempt));
      if (busy === 1'b1) check("gnt_onehot_sel", 32'(gnt), 32'(4'b0001 << sel));
    end
  endtask

  int order[5] = '{0, 1, 2, 3, 0};
  int npre;

  initial begin
    // 1: reset with all requests pending, then requester 0 wins first
    step(1, 4'b1111);
    step(1, 4'b1111);
    check("rst_gnt", 32'(gnt), 32'h0);
    step(0, 4'b1111);
    check("first_gnt", 32'(gnt), 32'h1);

    // 2: round robin 0,1,2,3,0 with 3-cycle grants and 1-cycle bubbles
    step(1, 4'b1111);
    for (int g = 0; g < 5; g++) begin
      step(0, 4'b1111);
      check("rr_order", 32'(sel), 32'(order[g]));
      step(0, 4'b1111);
      step(0, 4'b1111);
      step(0, 4'b1111 & ~(4'b0001 << (g % 4)));
      check("rr_bubble", 32'(gnt), 32'h0);
    end

    // 3: wrap from 3 to 0, then skip 1 to reach 2
    step(0, 4'b1000);
    check("wrap_owner3", 32'(gnt), 32'h8);
    step(0, 4'b0101);
    step(0, 4'b0101);
    check("wrap_to0", 32'(gnt), 32'h1);
    step(0, 4'b0101);
    step(0, 4'b0100);
    step(0, 4'b0100);
    check("skip_to2", 32'(gnt), 32'h4);
    step(0, 4'b0000);

    // 4: single requester pulsed repeatedly
    for (int p = 0; p < 5; p++) begin
      step(0, 4'b0100);
      check("single_gnt", 32'(gnt), 32'h4);
      step(0, 4'b0100);
      step(0, 4'b0000);
      check("single_release", 32'(gnt), 32'h0);
    end

`ifdef ARB_TIMEOUT_EN
    // 5: timeout preemption alternating between 0 and 1
    step(1, 4'b0011);
    npre = 0;
    for (int c = 0; c < 12; c++) begin
      step(0, 4'b0011);
      if (preempt === 1'b1) npre++;
    end
    check("to_preempt_cnt", 32'(npre), 32'd2);
    for (int c = 0; c < 10 && !(m_grant && m_hold == MAXH - 1); c++) step(0, 4'b0011);
    step(0, 4'b0010);
    check("to_release_wins", 32'(preempt), 32'd0);
    step(0, 4'b0000);
`endif

    // 6: reset mid-grant restores last=3
    step(0, 4'b0100);
    step(0, 4'b0100);
    check("mid_owner2", 32'(gnt), 32'h4);
    step(1, 4'b0100);
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    step(0, 4'b1001);
    check("mid_last_reset", 32'(gnt), 32'h1);
    step(0, 4'b1001);
    step(0, 4'b0000);

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
